data_mem_responder: RTL and testbench

//  Responder end of the core's data-memory interface: services load/store requests issued by the
//  MEM stage with a req/ready handshake and a parameterised number of wait states. Handles RV32

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_lane_fmt.sv | 47 ++++
 rtl/data_mem_responder.sv | 183 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states and counter width.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StAccess,
    StResp,
    StClear
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter: byte enables, replicated store data, extended load value and
// access-error flag (misalignment or the illegal size encoding) from size and address low bits.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic        uns,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] load,
  output logic        misalign
);

  logic [15:0] shifted;

  assign shifted = 16'(rword >> {lane, 3'b000});

  always_comb begin
    be       = 4'b0000;
    wword    = wdata;
    load     = '0;
    misalign = 1'b0;
    unique case (size)
      SZ_B: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
        load  = {{24{~uns & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        misalign = lane[0];
        be       = 4'b0011 << lane;
        wword    = {2{wdata[15:0]}};
        load     = {{16{~uns & shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        misalign = |lane;
        be       = 4'b1111;
        load     = rword;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: req/ready handshake with WAIT_STATES wait cycles over a word RAM.
// Define DMEM_CLEAR_EN to zero the whole RAM after every reset before accepting requests.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [WAIT_CNT_W-1:0] WaitInit =
      (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

`ifdef DMEM_CLEAR_EN
  localparam dmem_state_e ResetState = StClear;
`else
  localparam dmem_state_e ResetState = StIdle;
`endif

  dmem_state_e state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;

`ifdef DMEM_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
`endif

  logic [31:0] mem [Depth];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           rword;
  logic [3:0]            fmt_be;
  logic [31:0]           fmt_wword;
  logic [31:0]           fmt_load;
  logic                  fmt_misalign;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [3:0]            ram_be;
  logic [31:0]           ram_wdata;

  // Address bits above the RAM depth are deliberately ignored so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:ADDR_WIDTH+2];

  assign word_idx = addr_q[ADDR_WIDTH+1:2];
  assign rword    = mem[word_idx];

  dmem_lane_fmt u_lane_fmt (
    .size     (size_q),
    .lane     (addr_q[1:0]),
    .wdata    (wdata_q),
    .uns      (uns_q),
    .rword    (rword),
    .be       (fmt_be),
    .wword    (fmt_wword),
    .load     (fmt_load),
    .misalign (fmt_misalign)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ram_we    = 1'b0;
    ram_idx   = word_idx;
    ram_be    = fmt_be;
    ram_wdata = fmt_wword;
`ifdef DMEM_CLEAR_EN
    clr_idx_d = clr_idx_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          if (WAIT_STATES == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAccess: begin
        ram_we  = we_q & ~fmt_misalign;
        err_d   = fmt_misalign;
        rdata_d = (we_q | fmt_misalign) ? '0 : fmt_load;
        state_d = StResp;
      end
      // req_i here still belongs to the request being completed.
      StResp: state_d = StIdle;
`ifdef DMEM_CLEAR_EN
      StClear: begin
        ram_we    = 1'b1;
        ram_idx   = clr_idx_q;
        ram_be    = 4'b1111;
        ram_wdata = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ResetState;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= SZ_W;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef DMEM_CLEAR_EN
      clr_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DMEM_CLEAR_EN
      clr_idx_q <= clr_idx_d;
`endif
      if (state_q == StIdle && req_i) begin
        we_q    <= we_i;
        size_q  <= size_i;
        uns_q   <= unsigned_i;
        addr_q  <= addr_i[ADDR_WIDTH+1:0];
        wdata_q <= wdata_i;
      end
    end
  end

  // RAM is not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) begin
          mem[ram_idx][8*b+:8] <= ram_wdata[8*b+:8];
        end
      end
    end
  end

  assign ready_o = (state_q == StResp);
  assign rdata_o = ready_o ? rdata_q : '0;
  assign err_o   = ready_o & err_q;
  assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: dut0 has no wait states, dut1 has three; both share clock and reset.
module tb_data_mem_responder;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic        uns   [2];
  logic [1:0]  size  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];
  logic        busy  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we[0]), .size_i(size[0]),
    .unsigned_i(uns[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]),
    .ready_o(ready[0]), .err_o(err[0]), .busy_o(busy[0])
  );

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we[1]), .size_i(size[1]),
    .unsigned_i(uns[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]),
    .ready_o(ready[1]), .err_o(err[1]), .busy_o(busy[1])
  );

  typedef struct {
    int          d;
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input int d, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_err, input string name);
    vecs.push_back('{d, w, sz, u, a, wd, exp_rd, exp_err, name});
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (busy[d] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy[d]) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: dut%0d still busy after %0d cycles", d, n);
    end
  endtask

  task automatic do_access(input int d, input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd, input logic hold,
                           output logic [31:0] rd, output logic e, output int lat,
                           output int busy_n, output int leak);
    wait_idle(d);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; size[d] = sz; uns[d] = u; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    lat = 0; busy_n = 0; leak = 0; rd = '0; e = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy[d]) busy_n++;
      if (ready[d]) begin
        lat = k; rd = rdata[d]; e = err[d];
        break;
      end
      if (rdata[d] != 0 || err[d]) leak++;
    end
    if (hold) @(negedge clk);
    req[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat, busy_n, leak, n;
    logic [31:0] prior;

    for (int i = 0; i < 2; i++) begin
      req[i] = 0; we[i] = 0; uns[i] = 0; size[i] = W; addr[i] = 0; wdata[i] = 0;
    end

    add(0, 1, W, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, "sw_10");
    add(0, 0, W, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, "lw_10");
    add(0, 1, B, 0, 32'h11, 32'hFFFFFF7F, 32'h0,        0, "sb_11");
    add(0, 0, B, 0, 32'h11, 32'h0,        32'h0000007F, 0, "lb_11");
    add(0, 1, B, 0, 32'h12, 32'h12345680, 32'h0,        0, "sb_12");
    add(0, 0, B, 0, 32'h12, 32'h0,        32'hFFFFFF80, 0, "lb_12");
    add(0, 0, B, 1, 32'h12, 32'h0,        32'h00000080, 0, "lbu_12");
    add(0, 0, W, 0, 32'h10, 32'h0,        32'hDE807FEF, 0, "lw_10_merged");
    add(0, 1, W, 0, 32'h20, 32'h11223344, 32'h0,        0, "sw_20");
    add(0, 1, H, 0, 32'h22, 32'hAAAABEEF, 32'h0,        0, "sh_22");
    add(0, 0, H, 0, 32'h22, 32'h0,        32'hFFFFBEEF, 0, "lh_22");
    add(0, 0, H, 1, 32'h22, 32'h0,        32'h0000BEEF, 0, "lhu_22");
    add(0, 0, H, 0, 32'h21, 32'h0,        32'h0,        1, "lh_21_misalign");
    add(0, 1, W, 0, 32'h22, 32'hFFFFFFFF, 32'h0,        1, "sw_22_misalign");
    add(0, 0, W, 0, 32'h20, 32'h0,        32'hBEEF3344, 0, "lw_20_unchanged");
    add(0, 0, H, 0, 32'h20, 32'h0,        32'h00003344, 0, "lh_20");
    add(1, 1, W, 0, 32'h30, 32'hCAFEF00D, 32'h0,        0, "ws3_sw_30");
    add(1, 0, H, 0, 32'h32, 32'h0,        32'hFFFFCAFE, 0, "ws3_lh_32");
    add(1, 0, B, 1, 32'h31, 32'h0,        32'h000000F0, 0, "ws3_lbu_31");
    add(1, 0, B, 0, 32'h31, 32'h0,        32'hFFFFFFF0, 0, "ws3_lb_31");
    add(1, 0, X, 0, 32'h30, 32'h0,        32'h0,        1, "ws3_ld_size11");
    add(1, 1, X, 0, 32'h30, 32'h0,        32'h0,        1, "ws3_st_size11");
    add(1, 0, W, 0, 32'h30, 32'h0,        32'hCAFEF00D, 0, "ws3_lw_30");

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", 32'(ready[i]), 32'h0);
      check("rst_err",   32'(err[i]),   32'h0);
      check("rst_rdata", rdata[i],      32'h0);
    end
    rst = 1'b0;

`ifdef DMEM_CLEAR_EN
    // A store presented during CLEAR must be ignored.
    req[0] = 1; we[0] = 1; size[0] = W; addr[0] = 32'h0; wdata[0] = 32'hFFFFFFFF;
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k == 100) req[0] = 1'b0;
      if (!busy[0]) break;
      n++;
      @(negedge clk);
    end
    check("clear_busy_cycles", n, 1024);
    do_access(0, 0, W, 0, 32'h0, 0, 0, rd, e, lat, busy_n, leak);
    check("clear_lw_0", rd, 32'h0);
    do_access(0, 0, W, 0, 32'hFFC, 0, 0, rd, e, lat, busy_n, leak);
    check("clear_lw_ffc", rd, 32'h0);
    do_access(0, 0, W, 0, 32'h1234, 0, 0, rd, e, lat, busy_n, leak);
    check("clear_lw_1234", rd, 32'h0);
`else
    check("rst_busy0", 32'(busy[0]), 32'h0);
    check("rst_busy1", 32'(busy[1]), 32'h0);
`endif

    foreach (vecs[i]) begin
      do_access(vecs[i].d, vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, 1'b0,
                rd, e, lat, busy_n, leak);
      check({vecs[i].name, "_latency"}, lat, (vecs[i].d == 0) ? 2 : 5);
      check({vecs[i].name, "_busy"}, busy_n, (vecs[i].d == 0) ? 2 : 5);
      check({vecs[i].name, "_idle_zero"}, leak, 0);
      check({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].exp_err));
      if (!vecs[i].w) check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
    end

    // Request held across the RESP->IDLE edge must not start a second access.
    do_access(1, 0, W, 0, 32'h30, 0, 1'b1, rd, e, lat, busy_n, leak);
    check("hold_rdata", rd, 32'hCAFEF00D);
    check("hold_no_reaccept", 32'(busy[1]), 32'h0);

    // Reset during WAIT of a store: no response and no write.
    do_access(1, 1, W, 0, 32'h40, 32'h12345678, 0, rd, e, lat, busy_n, leak);
    wait_idle(1);
    @(negedge clk);
    req[1] = 1; we[1] = 1; size[1] = W; addr[1] = 32'h40; wdata[1] = 32'h1;
    @(posedge clk);
    @(negedge clk);
    check("mid_wait_busy", 32'(busy[1]), 32'h1);
    rst = 1'b1;
    req[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (ready[1]) n++;
      @(negedge clk);
    end
    check("mid_reset_no_ready", n, 0);
`ifdef DMEM_CLEAR_EN
    prior = 32'h0;
`else
    prior = 32'h12345678;
`endif
    do_access(1, 0, W, 0, 32'h40, 0, 0, rd, e, lat, busy_n, leak);
    check("mid_reset_lw_40", rd, prior);
    do_access(1, 0, W, 0, 32'h1040, 0, 0, rd, e, lat, busy_n, leak);
    check("alias_lw_1040", rd, prior);
    do_access(1, 1, W, 0, 32'h1044, 32'h0BADF00D, 0, rd, e, lat, busy_n, leak);
    do_access(1, 0, W, 0, 32'h44, 0, 0, rd, e, lat, busy_n, leak);
    check("alias_sw_1044_lw_44", rd, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
